mem_stage: RTL
==============

# mem_stage

Memory stage of the 16-bit pipelined datapath, sitting directly downstream of the EX stage's main ALU. It contains the EX/MEM pipeline register, a private data memory with a fixed multi-cycle access latency, and a small busy FSM. It back-pressures EX/ID/IF through `Stall` while an access is in flight, and presents a registered MEM/WB bundle to write-back.

## Interface
- `ADDR_W`, default 8: data-memory address width; depth is 2^ADDR_W words of 16 bits.
- `MEM_LATENCY`, default 2: cycles a load or store occupies the stage. Legal range is 1..15.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ValidIn`  in  1  EX presents an instruction this cycle.
- `ResultIn`  in  32  ALU result. `[15:0]` is the address for memory ops or the data otherwise; `[31:16]` is the OP2 half.
- `StoreDataIn`  in  16  store data (OP1).
- `DestRegIn`  in  4  destination register.
- `MemRead`, `MemWrite`, `RegWriteIn`, `WriteOP2In`  in  1 each  control bits from EX.
- `Stall`  out  1  EX and upstream stages must hold their inputs unchanged.
- `ValidOut`  out  1  MEM/WB bundle is valid this cycle.
- `ResultOut`  out  32  write-back data.
- `DestRegOut`  out  4  destination register.
- `RegWriteOut`, `WriteOP2Out`  out  1 each  write-back enables.
- `MemFault`  out  1  sticky address fault; only meaningful with `MEM_BOUNDS_CHECK_EN` defined.

## Operation
- FSM states:
  - IDLE: accepts `ValidIn`.
  - BUSY: a memory access is pending; a 4-bit counter tracks it.
- IDLE, `ValidIn=1`, neither `MemRead` nor `MemWrite`:
  - All inputs are registered to the outputs with `ValidOut=1` next cycle.
  - The state stays IDLE.
- IDLE, `ValidIn=1`, `MemRead` or `MemWrite` set:
  - Address, data, destination and control are captured.
  - The counter loads `MEM_LATENCY`, the state goes to BUSY, and `ValidOut=0` next cycle.
- BUSY:
  - `Stall=1`, and `ValidIn` is ignored.
  - The counter decrements each cycle.
  - On the edge at which the counter equals 1, the access is performed and the state returns to IDLE.
- Completion of the access:
  - Load: `ResultOut={16'h0000, mem[addr]}`, `RegWriteOut=1`, `WriteOP2Out=0`, `ValidOut=1` for one cycle.
  - Store: `mem[addr]<=StoreDataIn`, `ValidOut=1`, `RegWriteOut=0`, `WriteOP2Out=0`, `ResultOut` holds the captured `ResultIn`.
- `MemRead` and `MemWrite` both set: treated as a store only; no load result is produced.
- `addr=ResultIn[ADDR_W-1:0]`. Without the macro, the upper address bits are ignored, so address 0x0105 aliases 0x05 at `ADDR_W=8`.
- IDLE with `ValidIn=0`: `ValidOut=0` next cycle. The other outputs hold their last value, but `RegWriteOut` and `WriteOP2Out` are forced to 0 whenever `ValidOut=0`.
- Reset:
  - All outputs are 0, the state is IDLE, the counter is 0 and `MemFault=0`.
  - Memory contents are cleared to 0.
  - An in-flight access is abandoned and its store is not performed.

## Timing
- Non-memory op: latency 1. An input at cycle t appears at the outputs in cycle t+1; one op is accepted per cycle.
- Memory op accepted at cycle t:
  - `Stall=1` in cycles t+1..t+L (L = `MEM_LATENCY`).
  - The result or store completes at the end of cycle t+L.
  - `ValidOut=1` in cycle t+L+1.
- `Stall` is a registered output: it is `Stall = (state==BUSY)` and has no combinational path from the inputs.
- The instruction EX presents in cycle t+1 is held and accepted in cycle t+L+1, when `Stall=0`.
- Back-to-back memory ops: the second is accepted in t+L+1, so throughput is one memory op per L+1 cycles.
- Store followed by a load to the same address: the load returns the new data. There is no bypass hazard because the accesses are serialized.

## Configuration
- `MEM_BOUNDS_CHECK_EN` defined:
  - A memory op whose `ResultIn[15:ADDR_W]` is nonzero suppresses the access; a store does not write and a load returns 0 with `RegWriteOut=0`.
  - `MemFault` sets and stays high until `rst`.
  - The cycle timing is unchanged; the op still occupies L cycles.
- Not defined: upper address bits are ignored, `MemFault` is tied to 0, and no checking logic exists.

## Test plan
- Reset, then check all outputs and the state: all outputs 0, `Stall=0`, and a load from any address returns 0.
- ALU op with `ResultIn=32'h0003_0010`, `DestRegIn=4`, `RegWriteIn=1` at cycle t -> cycle t+1 shows `ValidOut=1`, `ResultOut=32'h0003_0010`, `DestRegOut=4`, `Stall=0` throughout.
- L=2: store `0xBEEF` to address `0x12` at cycle t -> `Stall=1` in t+1 and t+2, `ValidOut=1` with `RegWriteOut=0` in t+3. A following load of `0x12` -> `ResultOut=32'h0000_BEEF` with `RegWriteOut=1`, exactly 3 cycles after its acceptance.
- `MemRead=MemWrite=1`, store data `0x1234` to `0x20` -> memory at `0x20` is `0x1234` and `RegWriteOut=0`; a subsequent load of `0x20` returns `0x1234`.
- Store `0x5555` to `0x30`, assert `rst` in the first BUSY cycle -> `Stall` and `ValidOut` drop immediately, and a later load of `0x30` returns 0.
- Macro defined: load from `0x0105` -> `MemFault=1` (sticky), `RegWriteOut=0`, `ResultOut[15:0]=0`. Macro undefined: the same load returns `mem[0x05]`.

Source files
------------

// File: rtl/mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_stage: EX/MEM register, private multi-cycle data memory, MEM/WB output |
// | Optional: MEM_BOUNDS_CHECK_EN (suppress out-of-range accesses, MemFault)   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mem_stage #(
  parameter int ADDR_W      = 8,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidIn,
  input  logic [31:0] ResultIn,
  input  logic [15:0] StoreDataIn,
  input  logic [3:0]  DestRegIn,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWriteIn,
  input  logic        WriteOP2In,
  output logic        Stall,
  output logic        ValidOut,
  output logic [31:0] ResultOut,
  output logic [3:0]  DestRegOut,
  output logic        RegWriteOut,
  output logic        WriteOP2Out,
  output logic        MemFault
);

  localparam int         c_depth = 1 << ADDR_W;
  localparam logic [3:0] c_lat   = 4'(MEM_LATENCY);
  localparam logic [0:0] c_idle  = 1'b0;
  localparam logic [0:0] c_busy  = 1'b1;

  logic [0:0]        r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_result;
  logic [15:0]       r_data;
  logic [3:0]        r_dest;
  logic              r_is_store;
  logic [15:0]       r_mem [0:c_depth-1];

  logic              r_valid_o;
  logic [31:0]       r_result_o;
  logic [3:0]        r_dest_o;
  logic              r_regwr_o;
  logic              r_wop2_o;

  logic              w_memop;
  logic              w_suppress;

  assign w_memop = MemRead | MemWrite;

`ifdef MEM_BOUNDS_CHECK_EN
  logic r_oob;
  logic r_fault;
  logic w_oob_in;

  // Any nonzero address bit above the memory's range marks the access out of bounds.
  assign w_oob_in   = (ResultIn[15:0] >> ADDR_W) != 16'h0000;
  assign w_suppress = r_oob;
  assign MemFault   = r_fault;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_oob   <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      if (r_state == c_idle && ValidIn && w_memop)
        r_oob <= w_oob_in;
      if (r_state == c_busy && r_cnt == 4'd1 && r_oob)
        r_fault <= 1'b1;
    end
  end
`else
  assign w_suppress = 1'b0;
  assign MemFault   = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_idle;
      r_cnt      <= 4'd0;
      r_addr     <= '0;
      r_result   <= 32'h0;
      r_data     <= 16'h0;
      r_dest     <= 4'h0;
      r_is_store <= 1'b0;
      r_valid_o  <= 1'b0;
      r_result_o <= 32'h0;
      r_dest_o   <= 4'h0;
      r_regwr_o  <= 1'b0;
      r_wop2_o   <= 1'b0;
      for (int i = 0; i < c_depth; i++)
        r_mem[i] <= 16'h0;
    end else begin
      case (r_state)
        c_idle: begin
          if (ValidIn && w_memop) begin
            r_addr     <= ResultIn[ADDR_W-1:0];
            r_result   <= ResultIn;
            r_data     <= StoreDataIn;
            r_dest     <= DestRegIn;
            r_is_store <= MemWrite;
            r_cnt      <= c_lat;
            r_state    <= c_busy;
            r_valid_o  <= 1'b0;
            r_regwr_o  <= 1'b0;
            r_wop2_o   <= 1'b0;
          end else if (ValidIn) begin
            r_valid_o  <= 1'b1;
            r_result_o <= ResultIn;
            r_dest_o   <= DestRegIn;
            r_regwr_o  <= RegWriteIn;
            r_wop2_o   <= WriteOP2In;
          end else begin
            r_valid_o  <= 1'b0;
            r_regwr_o  <= 1'b0;
            r_wop2_o   <= 1'b0;
          end
        end
        c_busy: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state   <= c_idle;
            r_valid_o <= 1'b1;
            r_dest_o  <= r_dest;
            r_wop2_o  <= 1'b0;
            // A combined read+write request behaves purely as a store.
            if (r_is_store) begin
              if (!w_suppress)
                r_mem[r_addr] <= r_data;
              r_result_o <= r_result;
              r_regwr_o  <= 1'b0;
            end else if (w_suppress) begin
              r_result_o <= 32'h0;
              r_regwr_o  <= 1'b0;
            end else begin
              r_result_o <= {16'h0000, r_mem[r_addr]};
              r_regwr_o  <= 1'b1;
            end
          end else begin
            r_valid_o <= 1'b0;
            r_regwr_o <= 1'b0;
            r_wop2_o  <= 1'b0;
          end
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign Stall       = (r_state == c_busy);
  assign ValidOut    = r_valid_o;
  assign ResultOut   = r_result_o;
  assign DestRegOut  = r_dest_o;
  assign RegWriteOut = r_regwr_o;
  assign WriteOP2Out = r_wop2_o;

endmodule
`default_nettype wire
